// File: rtl/dr_pkg.sv
// Shared constants and FSM state type for the dual-rail link arbiter.
package dr_pkg;

  localparam int RAIL_NUM  = 2;
  localparam int RAIL_ZERO = 0;
  localparam int RAIL_ONE  = 1;

  localparam logic [RAIL_NUM-1:0] SPACER = '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_NULL,
    ST_DONE
  } state_t;

endpackage

// File: rtl/dr_link_arb_rr_arb.sv
// Round-robin selector: grants the requester closest at or after the pointer.
module rr_arb #(
  parameter int REQ_NUM = 4,
  parameter int PTR_W   = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
  input  logic [REQ_NUM-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [REQ_NUM-1:0] o_gnt
);

  int unsigned w_dist;
  int unsigned w_best;

  // Smallest circular distance from the pointer wins; distances are unique.
  always_comb begin
    o_gnt  = '0;
    w_dist = 0;
    w_best = REQ_NUM;
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      if (i >= 32'(i_ptr)) w_dist = i - 32'(i_ptr);
      else                 w_dist = i + REQ_NUM - 32'(i_ptr);
      if (i_req[i] && (w_dist < w_best)) begin
        w_best   = w_dist;
        o_gnt    = '0;
        o_gnt[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dr_link_arb.sv
// Round-robin arbiter driving a 4-phase dual-rail link from synchronous requesters.
// Optional macro DR_LINK_ARB_TIMEOUT_EN adds a sticky timeout_o for a stalled sink.
module dr_link_arb
  import dr_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int REQ_NUM = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [REQ_NUM-1:0]          req_i,
  input  logic [REQ_NUM*WIDTH-1:0]    data_i,
  output logic [REQ_NUM-1:0]          gnt_o,
  output logic [REQ_NUM-1:0]          done_o,
  input  logic                        ack_i,
  output logic [WIDTH*RAIL_NUM-1:0]   out_o,
  output logic                        busy_o
`ifdef DR_LINK_ARB_TIMEOUT_EN
  ,
  output logic                        timeout_o
`endif
);

  localparam int PTR_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
  localparam int OUT_W = WIDTH * RAIL_NUM;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_ack_meta;
  logic                 r_ack_s;
  logic [1:0]           r_sync_vld;
  logic [PTR_W-1:0]     r_ptr;
  logic [PTR_W-1:0]     r_owner;
  logic [PTR_W-1:0]     w_win_idx;
  logic [WIDTH-1:0]     r_payload;
  logic [WIDTH-1:0]     w_win_data;
  logic [WIDTH-1:0]     w_pay_nxt;
  logic [OUT_W-1:0]     r_out;
  logic [OUT_W-1:0]     w_enc;
  logic [REQ_NUM-1:0]   w_rr_gnt;
  logic                 w_start;

  // r_sync_vld holds off grants until the synchronizer has taken two real samples.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ack_meta <= 1'b0;
      r_ack_s    <= 1'b0;
      r_sync_vld <= '0;
    end else begin
      r_ack_meta <= ack_i;
      r_ack_s    <= r_ack_meta;
      r_sync_vld <= {r_sync_vld[0], 1'b1};
    end
  end

  rr_arb #(
    .REQ_NUM (REQ_NUM),
    .PTR_W   (PTR_W)
  ) u_rr_arb (
    .i_req (req_i),
    .i_ptr (r_ptr),
    .o_gnt (w_rr_gnt)
  );

  assign w_start = (r_state == ST_IDLE) && r_sync_vld[1] && !r_ack_s && (|req_i);

  always_comb begin
    w_win_idx  = '0;
    w_win_data = '0;
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      if (w_rr_gnt[i]) begin
        w_win_idx  = PTR_W'(i);
        w_win_data = data_i[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start)  w_state_nxt = ST_DATA;
      ST_DATA: if (r_ack_s)  w_state_nxt = ST_NULL;
      ST_NULL: if (!r_ack_s) w_state_nxt = ST_DONE;
      ST_DONE:               w_state_nxt = ST_IDLE;
      default:               w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt_o  = '0;
    done_o = '0;
    busy_o = (r_state != ST_IDLE);
    if (w_start) gnt_o = w_rr_gnt;
    if (r_state == ST_DONE) done_o[r_owner] = 1'b1;
  end

  assign w_pay_nxt = w_start ? w_win_data : r_payload;

  always_comb begin
    w_enc = '0;
    for (int unsigned b = 0; b < WIDTH; b++) begin
      w_enc[b*RAIL_NUM + RAIL_ONE]  = w_pay_nxt[b];
      w_enc[b*RAIL_NUM + RAIL_ZERO] = ~w_pay_nxt[b];
    end
  end

  // Link register follows the next state, so the codeword appears the cycle after the grant.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_payload <= '0;
      r_owner   <= '0;
      r_ptr     <= '0;
      r_out     <= {WIDTH{SPACER}};
    end else begin
      if (w_start) begin
        r_payload <= w_win_data;
        r_owner   <= w_win_idx;
        r_ptr     <= (w_win_idx == PTR_W'(REQ_NUM - 1)) ? '0 : w_win_idx + 1'b1;
      end
      r_out <= (w_state_nxt == ST_DATA) ? w_enc : {WIDTH{SPACER}};
    end
  end

  assign out_o = r_out;

`ifdef DR_LINK_ARB_TIMEOUT_EN
  logic [15:0] r_to_cnt;
  logic        r_timeout;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_state_nxt != r_state) begin
        r_to_cnt <= '0;
      end else if (((r_state == ST_DATA) || (r_state == ST_NULL)) && (r_to_cnt != '1)) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
      if (r_to_cnt == '1) r_timeout <= 1'b1;
    end
  end

  assign timeout_o = r_timeout;
`endif

endmodule

// File: tb/tb_dr_link_arb.sv
// Self-checking bench for dr_link_arb: transaction model, protocol checks, directed cases.
module tb_dr_link_arb;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int OW = 2 * W;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_i;
  logic [N*W-1:0]  data_i;
  logic [N-1:0]    gnt_o;
  logic [N-1:0]    done_o;
  logic            ack_i;
  logic [OW-1:0]   out_o;
  logic            busy_o;
  logic            ack_force;
  logic            sink_en;
  logic            sink_ack = 1'b0;
  int              cw_cnt = 0;
  int              sink_delay = 3;
`ifdef DR_LINK_ARB_TIMEOUT_EN
  logic            timeout_o;
`endif

  always #5 clk = ~clk;

  assign ack_i = sink_en ? sink_ack : ack_force;

  dr_link_arb #(
    .WIDTH   (W),
    .REQ_NUM (N)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .req_i  (req_i),
    .data_i (data_i),
    .gnt_o  (gnt_o),
    .done_o (done_o),
    .ack_i  (ack_i),
    .out_o  (out_o),
    .busy_o (busy_o)
`ifdef DR_LINK_ARB_TIMEOUT_EN
    ,
    .timeout_o (timeout_o)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [OW-1:0] enc(input logic [W-1:0] d);
    logic [OW-1:0] e;
    e = '0;
    for (int b = 0; b < W; b++) e[2*b +: 2] = d[b] ? 2'b10 : 2'b01;
    return e;
  endfunction

  function automatic int oh2i(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  // Transaction model: phase 0 idle, 1 codeword, 2 spacer wait, 3 completion.
  int          m_phase = 0;
  int          m_owner = 0;
  int          m_ptr = 0;
  int          m_age = 0;
  logic [W-1:0] m_pay = '0;
  logic [1:0]  m_hist = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_owner = 0; m_ptr = 0; m_age = 0; m_pay = '0; m_hist = '0;
    end else begin
      case (m_phase)
        0: if (m_age >= 2 && !m_hist[1] && req_i != '0) begin
             m_owner = pick(req_i, m_ptr);
             m_pay   = data_i[m_owner*W +: W];
             m_ptr   = (m_owner + 1) % N;
             m_phase = 1;
           end
        1: if (m_hist[1])  m_phase = 2;
        2: if (!m_hist[1]) m_phase = 3;
        default: m_phase = 0;
      endcase
      m_hist = {m_hist[0], ack_i};
      if (m_age < 2) m_age++;
    end
  end

  logic [OW-1:0] prev_out = '0;

  always @(negedge clk) begin : cmp
    logic [N-1:0]  eg;
    logic [N-1:0]  ed;
    logic          has11;
    eg = '0;
    ed = '0;
    if (!rst && m_phase == 0 && m_age >= 2 && !m_hist[1] && req_i != '0) eg[pick(req_i, m_ptr)] = 1'b1;
    if (m_phase == 3) ed[m_owner] = 1'b1;
    chk("out_o", out_o, (m_phase == 1) ? enc(m_pay) : '0);
    chk("gnt_o", gnt_o, eg);
    chk("done_o", done_o, ed);
    chk("busy_o", busy_o, m_phase != 0);
    has11 = 1'b0;
    for (int b = 0; b < W; b++) if (out_o[2*b +: 2] == 2'b11) has11 = 1'b1;
    chk("rail_11", has11, 0);
    chk("cw_to_cw", (prev_out != '0) && (out_o != '0) && (out_o != prev_out), 0);
    chk("gnt_onehot", $countones(gnt_o) <= 1, 1);
    chk("done_onehot", $countones(done_o) <= 1, 1);
    if (done_o != '0) done_cnt++;
    prev_out = out_o;
  end

  // Sink: acks sink_delay cycles after a codeword, releases once the spacer returns.
  always @(posedge clk) begin
    #1;
    if (sink_en) begin
      if (out_o != '0) begin
        if (!sink_ack) begin
          if (cw_cnt >= sink_delay) sink_ack = 1'b1;
          else cw_cnt++;
        end
      end else begin
        cw_cnt   = 0;
        sink_ack = 1'b0;
      end
    end
  end

  task automatic wait_gnt(output logic [N-1:0] g, output int k);
    g = '0;
    for (k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (gnt_o != '0) begin
        g = gnt_o;
        return;
      end
    end
    n_cmp++;
    n_bad++;
    $display("FAIL wait_gnt: got %0h required a grant within 200 cycles", gnt_o);
  endtask

  task automatic wait_done(output logic [N-1:0] d);
    d = '0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done_o != '0) begin
        d = done_o;
        return;
      end
    end
    n_cmp++;
    n_bad++;
    $display("FAIL wait_done: got %0h required a done pulse within 200 cycles", done_o);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [N-1:0] g;
    logic [N-1:0] d;
    int           k;
    int           order [5];
    int           done0;

    rst = 1'b1; req_i = '0; data_i = '0; ack_force = 1'b0; sink_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out", out_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_gnt", gnt_o, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // single request, payload 0xA5 on requester 2
    data_i[2*W +: W] = 8'hA5;
    req_i = 4'b0100;
    wait_gnt(g, k);
    chk("t1_gnt", g, 4'b0100);
    @(posedge clk);
    #1 req_i = '0;
    @(negedge clk);
    chk("t1_codeword", out_o, 16'h9966);
    wait_done(d);
    chk("t1_done", d, 4'b0100);
    repeat (5) @(negedge clk);
    chk("t1_done_count", done_cnt, 1);

    // round robin order from reset, requester 0 re-requests alongside 3
    @(posedge clk);
    #1 do_reset();
    data_i = {8'h44, 8'h33, 8'h22, 8'h11};
    req_i  = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_gnt(g, k);
      order[t] = oh2i(g);
      @(posedge clk);
      #1 req_i = req_i & ~g;
      if (t == 2) req_i = req_i | 4'b0001;
    end
    chk("t2_order0", order[0], 0);
    chk("t2_order1", order[1], 1);
    chk("t2_order2", order[2], 2);
    chk("t2_order3", order[3], 3);
    chk("t2_order4", order[4], 0);
    wait_done(d);
    chk("t2_last_done", d, 4'b0001);

    // ack held high through reset release blocks the grant
    @(posedge clk);
    #1 sink_en = 1'b0;
    ack_force = 1'b1;
    do_reset();
    data_i[1*W +: W] = 8'h5A;
    req_i = 4'b0010;
    repeat (8) begin
      @(negedge clk);
      chk("t3_blocked", gnt_o, 0);
    end
    @(posedge clk);
    #1 ack_force = 1'b0;
    wait_gnt(g, k);
    chk("t3_gnt", g, 4'b0010);
    chk("t3_wait", k, 3);
    @(posedge clk);
    #1 req_i = '0;
    sink_en = 1'b1;
    wait_done(d);
    chk("t3_done", d, 4'b0010);

    // reset during the codeword phase
    @(posedge clk);
    #1 data_i[3*W +: W] = 8'h3C;
    req_i = 4'b1000;
    wait_gnt(g, k);
    chk("t4_gnt", g, 4'b1000);
    @(posedge clk);
    #1 req_i = '0;
    @(negedge clk);
    chk("t4_codeword", out_o, 16'h5AA5);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t4_rst_out", out_o, 0);
    chk("t4_rst_busy", busy_o, 0);
    done0 = done_cnt;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("t4_no_done", done_cnt, done0);
    @(posedge clk);
    #1 req_i = 4'b1111;
    wait_gnt(g, k);
    chk("t4_gnt_after_rst", g, 4'b0001);
    @(posedge clk);
    #1 req_i = '0;
    wait_done(d);
    chk("t4_done", d, 4'b0001);
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
